// File: rtl/fq_defs.sv
// Shared entry layout, defaults and helpers for the fetch queue.
// Entry packing (LSB first): instruction, fetch PC, post-redirect jump marker.
package fq_defs;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    localparam int INSTR_LSB = 0;

    function automatic int pc_lsb(input int instr_w);
        return instr_w;
    endfunction

    function automatic int jump_bit(input int instr_w, input int addr_w);
        return instr_w + addr_w;
    endfunction

    function automatic int entry_w(input int instr_w, input int addr_w);
        return instr_w + addr_w + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fq_ring.sv
// DEPTH x W circular buffer with flush; pointers wrap mod DEPTH (any DEPTH >= 2).
// Latency: a pushed word is visible on rdat the cycle after the push.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module fq_ring
    import fq_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [W-1:0]                  wdat,
    output logic [W-1:0]                  rdat,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          empty,
    output logic                          full
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem[wr_ptr] <= wdat;
    end

    assign rdat  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: PC generation, I-cache handshake, DEPTH-entry prefetch queue.
// Latency: a hit is presented to decode the following cycle (no empty-queue bypass).
// Backpressure: stall holds the head; fetch continues until full, or when full and popping.
module fetch_queue
    import fq_defs::*;
#(
    parameter int                   ADDR_W    = ADDR_W_DEF,
    parameter int                   INSTR_W   = INSTR_W_DEF,
    parameter int                   DEPTH     = 4,
    parameter int                   PC_INC    = 1,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADDR_W-1:0]             i_addr,
    output logic                          i_re,
    input  logic                          i_hit,
    input  logic [INSTR_W-1:0]            instr,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    input  logic                          stall,
    output logic                          id_valid,
    output logic [INSTR_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]             id_pc,
    output logic                          id_jump,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int ENTRY_W = entry_w(INSTR_W, ADDR_W);
    localparam int PC_LSB  = pc_lsb(INSTR_W);
    localparam int JMP_BIT = jump_bit(INSTR_W, ADDR_W);

    logic [ADDR_W-1:0]  fetch_pc;
    logic               jmark;
    logic               push;
    logic               pop;
    logic               q_empty;
    logic               q_full;
    logic [ENTRY_W-1:0] wr_dat;
    logic [ENTRY_W-1:0] rd_dat;

    // A full queue may still fetch when the head leaves this same cycle.
    assign pop    = id_valid & ~stall & ~redirect;
    assign i_re   = ~redirect & (~q_full | pop);
    assign push   = i_re & i_hit;
    assign i_addr = fetch_pc;
    assign wr_dat = {jmark, fetch_pc, instr};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            jmark    <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            jmark    <= 1'b1;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            jmark    <= 1'b0;
        end
    end

    fq_ring #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdat  (wr_dat),
        .rdat  (rd_dat),
        .count (count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign id_valid = ~q_empty;
    assign id_instr = q_empty ? NOP_INSTR : rd_dat[INSTR_LSB +: INSTR_W];
    assign id_pc    = q_empty ? '0        : rd_dat[PC_LSB +: ADDR_W];
    assign id_jump  = ~q_empty & rd_dat[JMP_BIT];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench: default instance (DEPTH=4) plus a DEPTH=3 / RESET_PC=0xFFFE instance.
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Instance A: defaults
    logic        a_rst, a_i_re, a_i_hit, a_redirect, a_stall;
    logic        a_id_valid, a_id_jump;
    logic [15:0] a_i_addr, a_instr, a_redirect_pc, a_id_instr, a_id_pc;
    logic [2:0]  a_count;

    // Instance B: DEPTH=3, RESET_PC=0xFFFE
    logic        b_rst, b_i_re, b_i_hit, b_redirect, b_stall;
    logic        b_id_valid, b_id_jump;
    logic [15:0] b_i_addr, b_instr, b_redirect_pc, b_id_instr, b_id_pc;
    logic [1:0]  b_count;

    // I-cache model: data is the address scrambled by a fixed pattern.
    assign a_instr = a_i_addr ^ 16'h5A5A;
    assign b_instr = b_i_addr ^ 16'h5A5A;

    fetch_queue dut_a (
        .clk(clk), .rst(a_rst), .i_addr(a_i_addr), .i_re(a_i_re), .i_hit(a_i_hit),
        .instr(a_instr), .redirect(a_redirect), .redirect_pc(a_redirect_pc),
        .stall(a_stall), .id_valid(a_id_valid), .id_instr(a_id_instr),
        .id_pc(a_id_pc), .id_jump(a_id_jump), .count(a_count)
    );

    fetch_queue #(.DEPTH(3), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(b_rst), .i_addr(b_i_addr), .i_re(b_i_re), .i_hit(b_i_hit),
        .instr(b_instr), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
        .stall(b_stall), .id_valid(b_id_valid), .id_instr(b_id_instr),
        .id_pc(b_id_pc), .id_jump(b_id_jump), .count(b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; a_i_hit = 1'b1; a_redirect = 1'b0; a_stall = 1'b0;
        a_redirect_pc = 16'h0000;
        tick(); tick();
        total_cnt++; if (a_id_valid !== 1'b0) $display("FAIL rst_valid got %0d want 0", a_id_valid); else pass_cnt++;
        total_cnt++; if (a_id_instr !== 16'h0000) $display("FAIL rst_instr got %h want 0000", a_id_instr); else pass_cnt++;
        total_cnt++; if (a_id_pc !== 16'h0000) $display("FAIL rst_pc got %h want 0000", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_jump !== 1'b0) $display("FAIL rst_jump got %0d want 0", a_id_jump); else pass_cnt++;
        total_cnt++; if (a_count !== 3'd0) $display("FAIL rst_count got %0d want 0", a_count); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0000) $display("FAIL rst_iaddr got %h want 0000", a_i_addr); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [15:0] k16;
        a_rst = 1'b1;
        #1;
        total_cnt++; if (a_i_addr !== 16'h0000) $display("FAIL stream_first_addr got %h want 0000", a_i_addr); else pass_cnt++;
        total_cnt++; if (a_id_valid !== 1'b0) $display("FAIL stream_no_bypass got %0d want 0", a_id_valid); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            k16 = 16'(k);
            total_cnt++; if (a_id_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0d want 1", k, a_id_valid); else pass_cnt++;
            total_cnt++; if (a_id_pc !== k16) $display("FAIL stream_pc[%0d] got %h want %h", k, a_id_pc, k16); else pass_cnt++;
            total_cnt++; if (a_id_instr !== (k16 ^ 16'h5A5A)) $display("FAIL stream_instr[%0d] got %h want %h", k, a_id_instr, k16 ^ 16'h5A5A); else pass_cnt++;
            total_cnt++; if (a_id_jump !== 1'b0) $display("FAIL stream_jump[%0d] got %0d want 0", k, a_id_jump); else pass_cnt++;
            total_cnt++; if (a_i_addr !== k16 + 16'd1) $display("FAIL stream_addr[%0d] got %h want %h", k, a_i_addr, k16 + 16'd1); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1; a_stall = 1'b1; a_i_hit = 1'b1;
        repeat (6) tick();
        total_cnt++; if (a_count !== 3'd4) $display("FAIL stall_count got %0d want 4", a_count); else pass_cnt++;
        total_cnt++; if (a_i_re !== 1'b0) $display("FAIL stall_ire got %0d want 0", a_i_re); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0004) $display("FAIL stall_addr got %h want 0004", a_i_addr); else pass_cnt++;
        total_cnt++; if (a_id_pc !== 16'h0000) $display("FAIL stall_head got %h want 0000", a_id_pc); else pass_cnt++;
        a_stall = 1'b0;
        #1;
        total_cnt++; if (a_i_re !== 1'b1) $display("FAIL full_pop_ire got %0d want 1", a_i_re); else pass_cnt++;
        tick();
        total_cnt++; if (a_count !== 3'd4) $display("FAIL full_pop_count got %0d want 4", a_count); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0005) $display("FAIL full_pop_addr got %h want 0005", a_i_addr); else pass_cnt++;
        total_cnt++; if (a_id_pc !== 16'h0001) $display("FAIL full_pop_head got %h want 0001", a_id_pc); else pass_cnt++;
    endtask

    task automatic test_miss();
        tick(); tick();
        total_cnt++; if (a_i_addr !== 16'h0007) $display("FAIL miss_setup_addr got %h want 0007", a_i_addr); else pass_cnt++;
        a_i_hit = 1'b0;
        tick();
        total_cnt++; if (a_count !== 3'd3) $display("FAIL miss_setup_count got %0d want 3", a_count); else pass_cnt++;
        a_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++; if (a_i_re !== 1'b1) $display("FAIL miss_ire[%0d] got %0d want 1", k, a_i_re); else pass_cnt++;
            total_cnt++; if (a_i_addr !== 16'h0007) $display("FAIL miss_addr[%0d] got %h want 0007", k, a_i_addr); else pass_cnt++;
            total_cnt++; if (a_count !== 3'd3) $display("FAIL miss_count[%0d] got %0d want 3", k, a_count); else pass_cnt++;
        end
        a_i_hit = 1'b1;
        tick();
        total_cnt++; if (a_count !== 3'd4) $display("FAIL miss_hit_count got %0d want 4", a_count); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0008) $display("FAIL miss_hit_addr got %h want 0008", a_i_addr); else pass_cnt++;
        a_i_hit = 1'b0; a_stall = 1'b0;
        repeat (3) tick();
        total_cnt++; if (a_id_pc !== 16'h0007) $display("FAIL miss_tail_pc got %h want 0007", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_instr !== (16'h0007 ^ 16'h5A5A)) $display("FAIL miss_tail_instr got %h want %h", a_id_instr, 16'h0007 ^ 16'h5A5A); else pass_cnt++;
        total_cnt++; if (a_count !== 3'd1) $display("FAIL miss_tail_count got %0d want 1", a_count); else pass_cnt++;
    endtask

    task automatic test_redirect();
        a_stall = 1'b1; a_i_hit = 1'b1;
        tick(); tick();
        total_cnt++; if (a_count !== 3'd3) $display("FAIL redir_setup_count got %0d want 3", a_count); else pass_cnt++;
        a_redirect = 1'b1; a_redirect_pc = 16'h0040;
        #1;
        total_cnt++; if (a_i_re !== 1'b0) $display("FAIL redir_ire got %0d want 0", a_i_re); else pass_cnt++;
        tick();
        a_redirect = 1'b0;
        #1;
        total_cnt++; if (a_count !== 3'd0) $display("FAIL redir_count got %0d want 0", a_count); else pass_cnt++;
        total_cnt++; if (a_id_valid !== 1'b0) $display("FAIL redir_valid got %0d want 0", a_id_valid); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0040) $display("FAIL redir_addr got %h want 0040", a_i_addr); else pass_cnt++;
        a_stall = 1'b0;
        tick();
        total_cnt++; if (a_id_pc !== 16'h0040) $display("FAIL redir_first_pc got %h want 0040", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_jump !== 1'b1) $display("FAIL redir_first_jump got %0d want 1", a_id_jump); else pass_cnt++;
        tick();
        total_cnt++; if (a_id_pc !== 16'h0041) $display("FAIL redir_second_pc got %h want 0041", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_jump !== 1'b0) $display("FAIL redir_second_jump got %0d want 0", a_id_jump); else pass_cnt++;
        a_redirect = 1'b1; a_redirect_pc = 16'h0080;
        tick();
        a_redirect_pc = 16'h0090;
        tick();
        a_redirect = 1'b0;
        tick();
        total_cnt++; if (a_id_pc !== 16'h0090) $display("FAIL b2b_redir_pc got %h want 0090", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_jump !== 1'b1) $display("FAIL b2b_redir_jump got %0d want 1", a_id_jump); else pass_cnt++;
    endtask

    task automatic test_reset_mid_miss();
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1; a_stall = 1'b1; a_i_hit = 1'b1;
        tick(); tick();
        a_i_hit = 1'b0;
        tick();
        total_cnt++; if (a_count !== 3'd2) $display("FAIL rmiss_setup_count got %0d want 2", a_count); else pass_cnt++;
        total_cnt++; if (a_i_re !== 1'b1) $display("FAIL rmiss_setup_ire got %0d want 1", a_i_re); else pass_cnt++;
        a_rst = 1'b0; a_redirect = 1'b1; a_redirect_pc = 16'h0055;
        tick();
        a_redirect = 1'b0;
        #1;
        total_cnt++; if (a_id_valid !== 1'b0) $display("FAIL rmiss_valid got %0d want 0", a_id_valid); else pass_cnt++;
        total_cnt++; if (a_id_instr !== 16'h0000) $display("FAIL rmiss_instr got %h want 0000", a_id_instr); else pass_cnt++;
        total_cnt++; if (a_id_pc !== 16'h0000) $display("FAIL rmiss_pc got %h want 0000", a_id_pc); else pass_cnt++;
        total_cnt++; if (a_id_jump !== 1'b0) $display("FAIL rmiss_jump got %0d want 0", a_id_jump); else pass_cnt++;
        total_cnt++; if (a_count !== 3'd0) $display("FAIL rmiss_count got %0d want 0", a_count); else pass_cnt++;
        total_cnt++; if (a_i_addr !== 16'h0000) $display("FAIL rmiss_addr got %h want 0000", a_i_addr); else pass_cnt++;
        a_rst = 1'b1;
    endtask

    task automatic test_wrap();
        logic [15:0] pat;
        logic [15:0] exp_pc;
        int          pops;
        pat    = 16'b0101_1001_0011_0110;
        exp_pc = 16'hFFFE;
        pops   = 0;
        b_rst = 1'b0; b_i_hit = 1'b1; b_stall = 1'b1; b_redirect = 1'b0; b_redirect_pc = 16'h0000;
        tick();
        b_rst = 1'b1;
        #1;
        total_cnt++; if (b_i_addr !== 16'hFFFE) $display("FAIL wrap_reset_addr got %h want fffe", b_i_addr); else pass_cnt++;
        repeat (4) tick();
        total_cnt++; if (b_count !== 2'd3) $display("FAIL wrap_full_count got %0d want 3", b_count); else pass_cnt++;
        total_cnt++; if (b_i_re !== 1'b0) $display("FAIL wrap_full_ire got %0d want 0", b_i_re); else pass_cnt++;
        total_cnt++; if (b_i_addr !== 16'h0001) $display("FAIL wrap_full_addr got %h want 0001", b_i_addr); else pass_cnt++;
        for (int i = 0; i < 30; i++) begin
            b_stall = pat[i % 16];
            #1;
            if (b_id_valid && !b_stall) begin
                total_cnt++; if (b_id_pc !== exp_pc) $display("FAIL wrap_order_pc[%0d] got %h want %h", i, b_id_pc, exp_pc); else pass_cnt++;
                total_cnt++; if (b_id_instr !== (exp_pc ^ 16'h5A5A)) $display("FAIL wrap_order_instr[%0d] got %h want %h", i, b_id_instr, exp_pc ^ 16'h5A5A); else pass_cnt++;
                total_cnt++; if (b_id_jump !== 1'b0) $display("FAIL wrap_jump[%0d] got %0d want 0", i, b_id_jump); else pass_cnt++;
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            tick();
        end
        total_cnt++; if (pops < 10) $display("FAIL wrap_pop_count got %0d want >=10", pops); else pass_cnt++;
    endtask

    initial begin
        a_rst = 1'b0; a_i_hit = 1'b0; a_redirect = 1'b0; a_stall = 1'b0; a_redirect_pc = 16'h0000;
        b_rst = 1'b0; b_i_hit = 1'b0; b_redirect = 1'b0; b_stall = 1'b0; b_redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_miss();
        test_redirect();
        test_reset_mid_miss();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor of the single-slot IF stage (PC register, instruction mux and IF/ID register): a decoupled instruction-fetch unit with a DEPTH-entry prefetch buffer between the I-cache port and decode.
- Keeps fetching across I-cache hits while decode is stalled. Holds the PC on misses. Flushes and redirects on jump or branch-miss.
- Tags each queued instruction with its PC and a post-redirect marker.

Parameters:
- ADDR_W, 16, width of PC / i_addr.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch entries; must be >= 2, need not be a power of two.
- PC_INC, 1, PC increment per fetched instruction.
- RESET_PC, 0, fetch address after reset.
- NOP_INSTR, 16'h0000, value driven on id_instr when the queue is empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- i_addr  out  ADDR_W  fetch address to I-cache; equals the fetch_pc register.
- i_re  out  1  fetch request this cycle.
- i_hit  in  1  instr is valid for i_addr this cycle.
- instr  in  INSTR_W  instruction data from I-cache.
- redirect  in  1  jump / branch-miss / exception redirect.
- redirect_pc  in  ADDR_W  target address of the redirect.
- stall  in  1  decode cannot accept this cycle.
- id_valid  out  1  head entry valid.
- id_instr  out  INSTR_W  head instruction, or NOP_INSTR when empty.
- id_pc  out  ADDR_W  PC of the head instruction, or 0 when empty.
- id_jump  out  1  head is the first instruction fetched after a redirect.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0 at posedge):
  - fetch_pc=RESET_PC; queue empty (rd/wr pointers 0, count 0); redirect marker cleared.
  - Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_jump=0, count=0, i_addr=RESET_PC.
  - Reset dominates every other input, including mid-miss and mid-redirect.
- pop = id_valid & ~stall & ~redirect.
- i_re = ~redirect & ((count < DEPTH) | pop).
  - Full with pop in the same cycle is allowed to fetch; this is the only combinational path from stall to i_re.
- push = i_re & i_hit.
  - Writes {instr, fetch_pc, jmark} at wr_ptr.
  - fetch_pc <= fetch_pc + PC_INC, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 at defaults).
- Miss (i_re & ~i_hit): fetch_pc held and i_re stays asserted. Miss length is unbounded; nothing is pushed.
- Occupancy:
  - count <= count + push - pop.
  - Push and pop in the same cycle with count==DEPTH or count==0 must both succeed.
  - Empty queue: no bypass from instr to id_*. A fetched instruction appears on id_* the cycle after its hit, so minimum fetch-to-decode latency is 1 cycle.
- Pointers advance mod DEPTH: DEPTH-1 wraps to 0; no power-of-two arithmetic.
- Redirect (redirect=1 at posedge):
  - Queue flushed: count=0, pointers=0.
  - fetch_pc <= redirect_pc; jmark <= 1.
  - Any i_hit that cycle is discarded, and no pop occurs.
  - Next cycle: id_valid=0, i_addr=redirect_pc.
- jmark: set by redirect, cleared on the first push after it. That push stores jump=1; all other pushes store 0.
- Back-to-back redirects: the last one wins and jmark stays set.
- Head outputs are driven combinationally from storage at rd_ptr and gated by ~empty.
- Stall with empty queue has no effect on state except allowing a fetch.

Decomposition:
- Shared package/header fq_defs holds the entry-field layout constants (INSTR, PC and JUMP bit offsets, ENTRY_W = INSTR_W+ADDR_W+1), the NOP_INSTR default and the clog2 helper.
- Sub-module fq_ring: DEPTH x ENTRY_W circular buffer with push/pop/flush, wrap-mod-DEPTH pointers and count.
- The top level holds fetch_pc, jmark and the handshake logic.

Test Plan:
- Reset then constant i_hit=1, stall=0:
  - i_addr steps 0,1,2,3...
  - id_valid rises 1 cycle after the first hit.
  - id_pc sequence 0,1,2...; id_jump=0 throughout.
- stall=1 with i_hit=1, DEPTH=4:
  - Exactly 4 pushes; count=4; i_re=0; i_addr frozen at 4.
  - Release stall: one pop and one push in the same cycle; count stays 4.
- i_hit=0 for 5 cycles at i_addr=0x0007:
  - i_re held 1, i_addr held 0x0007, count unchanged by fetch.
  - The hit then pushes PC 0x0007.
- redirect=1, redirect_pc=0x0040 with count=3 and i_hit=1 that cycle:
  - Next cycle count=0, id_valid=0, i_addr=0x0040.
  - The first delivered entry has id_pc=0x0040, id_jump=1; the following entry has id_jump=0.
- DEPTH=3, RESET_PC=0xFFFE, stall toggled:
  - PC wraps 0xFFFE, 0xFFFF, 0x0000.
  - Pointer wrap across 10+ entries preserves order with no loss or duplication.
- Assert rst=0 during a miss with count=2:
  - Next cycle all outputs are at reset values and i_addr=RESET_PC.
